// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: one-outstanding fetch FSM feeding an in-order {pc, instruction} queue.
// Optional JAL next-pc prediction is compiled in when IFU_JAL_PREDICT_EN is defined.
module inst_fetch_unit #(
    parameter int          QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        inst_pred_taken,
    input  logic        dec_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int          PW      = $clog2(QUEUE_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW:0]   count_q;
    logic          mem_req_valid_q;
    logic [31:0]   mem_req_addr_q;

    logic [31:0]   pc_mem   [QUEUE_DEPTH];
    logic [31:0]   data_mem [QUEUE_DEPTH];

    logic          enq;
    logic          pop;
    logic [31:0]   next_pc_d;

    // rdy_in low or a redirect suppresses every normal queue movement.
    assign inst_valid = (count_q != '0);
    assign enq = rdy_in && !redirect_valid && (state_q == S_WAIT) && mem_resp_valid;
    assign pop = rdy_in && !redirect_valid && inst_valid && dec_ready;

`ifdef IFU_JAL_PREDICT_EN
    logic          resp_is_jal;
    logic [31:0]   jal_off;
    logic          pred_mem [QUEUE_DEPTH];

    assign resp_is_jal = (mem_resp_data[6:0] == 7'b1101111);
    assign jal_off     = {{11{mem_resp_data[31]}}, mem_resp_data[31], mem_resp_data[19:12],
                          mem_resp_data[20], mem_resp_data[30:21], 1'b0};
    assign next_pc_d   = resp_is_jal ? (fetch_pc_q + jal_off) : (fetch_pc_q + 32'd4);
    assign inst_pred_taken = inst_valid ? pred_mem[head_q] : 1'b0;

    always_ff @(posedge clk_in) begin
        if (enq) begin
            pred_mem[tail_q] <= resp_is_jal;
        end
    end
`else
    assign next_pc_d       = fetch_pc_q + 32'd4;
    assign inst_pred_taken = 1'b0;
`endif

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign inst_pc       = inst_valid ? pc_mem[head_q]   : 32'h0;
    assign inst_data     = inst_valid ? data_mem[head_q] : 32'h0;

    always_ff @(posedge clk_in) begin
        if (enq) begin
            pc_mem[tail_q]   <= fetch_pc_q;
            data_mem[tail_q] <= mem_resp_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= S_IDLE;
            fetch_pc_q      <= RESET_PC;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= 32'h0;
        end else if (rdy_in) begin
            if (redirect_valid) begin
                fetch_pc_q      <= redirect_pc & ~32'h3;
                head_q          <= '0;
                tail_q          <= '0;
                count_q         <= '0;
                mem_req_valid_q <= 1'b0;
                // An outstanding fetch must still be absorbed before new requests go out.
                case (state_q)
                    S_WAIT, S_DISCARD: state_q <= mem_resp_valid ? S_IDLE : S_DISCARD;
                    default:           state_q <= S_IDLE;
                endcase
            end else begin
                case ({enq, pop})
                    2'b10: begin
                        tail_q  <= tail_q + 1'b1;
                        count_q <= count_q + 1'b1;
                    end
                    2'b01: begin
                        head_q  <= head_q + 1'b1;
                        count_q <= count_q - 1'b1;
                    end
                    2'b11: begin
                        tail_q <= tail_q + 1'b1;
                        head_q <= head_q + 1'b1;
                    end
                    default: ;
                endcase

                case (state_q)
                    S_IDLE: begin
                        if (count_q < DEPTH_C) begin
                            state_q         <= S_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= fetch_pc_q;
                        end
                    end
                    S_REQ: begin
                        if (mem_req_valid_q && mem_req_ready) begin
                            state_q         <= S_WAIT;
                            mem_req_valid_q <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (mem_resp_valid) begin
                            state_q    <= S_IDLE;
                            fetch_pc_q <= next_pc_d;
                        end
                    end
                    default: begin
                        if (mem_resp_valid) begin
                            state_q <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed + randomized bench for inst_fetch_unit: the bench plays the memory controller and
// keeps a queue-based model of the expected instruction stream.
module tb_inst_fetch_unit;

    localparam int DEPTH = 8;
`ifdef IFU_JAL_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_pred_taken;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk_in = ~clk_in;

    inst_fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .inst_valid      (inst_valid),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data),
        .inst_pred_taken (inst_pred_taken),
        .dec_ready       (dec_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        pred;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        mq[$];
    logic [31:0] acc_q[$];
    logic [31:0] exp_fetch;
    logic [31:0] pend_pc;
    bit          pend, flushed;
    int          lat, lat_lo, lat_hi, pops;
    bit          resp_en, frc_resp;
    bit          k_rdy, k_mrdy, k_drdy, k_redir;
    logic [31:0] k_rpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory contents: two fixed words used by directed steps, everything else a non-JAL ALU op.
    function automatic logic [31:0] word_of(input logic [31:0] pc);
        if (pc == 32'h0)  return 32'h0050_0093;
        if (pc == 32'h40) return 32'h0100_006F;
        return {pc[26:2] ^ 25'h0155AA3, 7'b0010011};
    endfunction

    function automatic bit predicts(input logic [31:0] w);
        return PRED_EN && (w[6:0] == 7'b1101111);
    endfunction

    function automatic logic [31:0] next_of(input logic [31:0] pc, input logic [31:0] w);
        logic [20:0] imm;
        int          off;
        if (!predicts(w)) return pc + 32'd4;
        imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        off = int'(imm) - (imm[20] ? (1 << 21) : 0);
        return pc + 32'(off);
    endfunction

    // One clock: score the settled outputs, drive knobs, advance the model, then step to the next negedge.
    task automatic tick();
        bit   do_resp, accept, popped;
        ent_t e;
        chk("inst_valid", inst_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("head_pc", inst_pc, mq[0].pc);
            chk("head_data", inst_data, mq[0].data);
            chk("head_pred", inst_pred_taken, mq[0].pred);
        end
        chk("req_space", mem_req_valid && (pend || mq.size() >= DEPTH), 0);

        rdy_in         = k_rdy;
        mem_req_ready  = k_mrdy;
        dec_ready      = k_drdy;
        redirect_valid = k_redir;
        redirect_pc    = k_rpc;
        do_resp        = k_rdy && resp_en && pend && (lat == 0);
        mem_resp_valid = do_resp || (!k_rdy && frc_resp);
        mem_resp_data  = do_resp ? word_of(pend_pc) : $urandom;

        if (k_rdy) begin
            accept = mem_req_valid && k_mrdy && !k_redir;
            if (k_redir) begin
                mq.delete();
                exp_fetch = k_rpc & ~32'h3;
                if (do_resp) begin
                    pend = 0;
                    flushed = 0;
                end else if (pend) begin
                    flushed = 1;
                end
            end else begin
                popped = (mq.size() != 0) && k_drdy;
                if (popped) begin
                    void'(mq.pop_front());
                    pops++;
                end
                if (do_resp) begin
                    pend = 0;
                    if (flushed) begin
                        flushed = 0;
                    end else begin
                        e.pc   = pend_pc;
                        e.data = word_of(pend_pc);
                        e.pred = predicts(e.data);
                        mq.push_back(e);
                        exp_fetch = next_of(pend_pc, e.data);
                    end
                end
            end
            if (pend && !do_resp && resp_en && lat > 0) lat--;
            if (accept) begin
                chk("req_addr", mem_req_addr, exp_fetch);
                acc_q.push_back(mem_req_addr);
                pend    = 1;
                pend_pc = exp_fetch;
                lat     = $urandom_range(lat_hi, lat_lo);
            end
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drain();
        k_mrdy  = 0;
        resp_en = 1;
        for (int i = 0; i < 20 && pend; i++) tick();
        chk("drain_done", pend, 0);
    endtask

    logic [31:0] s_addr, s_pc;
    logic        s_rv, s_iv;

    initial begin
        rst_in = 0; rdy_in = 1; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        dec_ready = 0; redirect_valid = 0; redirect_pc = 0;
        k_rdy = 1; k_mrdy = 1; k_drdy = 0; k_redir = 0; k_rpc = 0;
        resp_en = 1; frc_resp = 0; lat_lo = 1; lat_hi = 1; lat = 0;
        pend = 0; flushed = 0; pops = 0; exp_fetch = 32'h0; pend_pc = 0;
        repeat (3) @(negedge clk_in);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_pred", inst_pred_taken, 0);
        rst_in = 1;

        // First fetch: request one edge after release, response two cycles after acceptance.
        chk("t1_req_pre", mem_req_valid, 0);
        tick();
        chk("t1_req_valid", mem_req_valid, 1);
        chk("t1_req_addr", mem_req_addr, 32'h0);
        for (int i = 0; i < 10 && !inst_valid; i++) tick();
        chk("t1_valid", inst_valid, 1);
        chk("t1_pc", inst_pc, 32'h0);
        chk("t1_data", inst_data, 32'h0050_0093);

        // Fill the queue with the decoder stalled.
        lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < 100 && mq.size() < DEPTH; i++) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_full_no_req", mem_req_valid, 0);
        end
        chk("t2_accepts", acc_q.size(), 8);
        chk("t2_head_pc", inst_pc, 32'h0);
        k_drdy = 1; tick(); k_drdy = 0;
        tick();
        chk("t2_refill_valid", mem_req_valid, 1);
        chk("t2_refill_addr", mem_req_addr, 32'h20);

        // Redirect while WAIT; the stale response arrives one cycle later and must vanish.
        drain();
        k_redir = 1; k_rpc = 32'h8; tick(); k_redir = 0;
        k_mrdy = 1; resp_en = 0; acc_q.delete();
        for (int i = 0; i < 10 && !pend; i++) tick();
        chk("t3_acc_8", acc_q.size() > 0 ? acc_q[0] : 32'hxxxx_xxxx, 32'h8);
        k_redir = 1; k_rpc = 32'h100; tick(); k_redir = 0;
        resp_en = 1; acc_q.delete();
        for (int i = 0; i < 20 && mq.size() == 0; i++) tick();
        chk("t3_next_req", acc_q.size() > 0 ? acc_q[0] : 32'hxxxx_xxxx, 32'h100);
        chk("t3_valid", inst_valid, 1);
        chk("t3_pc", inst_pc, 32'h100);
        chk("t3_data", inst_data, word_of(32'h100));

        // Redirect and pop in the same cycle.
        for (int i = 0; i < 30 && mq.size() < 3; i++) tick();
        chk("t4_three", inst_valid && mq.size() >= 3, 1);
        k_redir = 1; k_rpc = 32'h200; k_drdy = 1; tick(); k_redir = 0; k_drdy = 0;
        chk("t4_flushed", inst_valid, 0);
        chk("t4_no_req", mem_req_valid, 0);

        // Freeze mid-WAIT with noise on every ignored input.
        drain();
        k_mrdy = 1; resp_en = 0;
        for (int i = 0; i < 10 && !pend; i++) tick();
        s_rv = mem_req_valid; s_addr = mem_req_addr; s_iv = inst_valid; s_pc = inst_pc;
        chk("t5_in_wait", pend, 1);
        k_rdy = 0; frc_resp = 1; k_drdy = 1; resp_en = 1;
        for (int i = 0; i < 5; i++) begin
            k_redir = i[0]; k_rpc = 32'h300;
            tick();
            chk("t5_frz_rv", mem_req_valid, s_rv);
            chk("t5_frz_addr", mem_req_addr, s_addr);
            chk("t5_frz_iv", inst_valid, s_iv);
            chk("t5_frz_pc", inst_pc, s_pc);
        end
        k_rdy = 1; frc_resp = 0; k_redir = 0; k_drdy = 0;
        for (int i = 0; i < 10 && mq.size() == 0; i++) tick();
        chk("t5_resume_pc", inst_pc, 32'h200);
        chk("t5_resume_data", inst_data, word_of(32'h200));

        // JAL at 0x40: the follow-up request address depends on prediction being built in.
        lat_hi = 2;
        k_redir = 1; k_rpc = 32'h40; tick(); k_redir = 0;
        acc_q.delete();
        for (int i = 0; i < 40 && acc_q.size() < 2; i++) tick();
        chk("t6_first_req", acc_q.size() > 0 ? acc_q[0] : 32'hxxxx_xxxx, 32'h40);
        chk("t6_next_req", acc_q.size() > 1 ? acc_q[1] : 32'hxxxx_xxxx, PRED_EN ? 32'h50 : 32'h44);
        chk("t6_pc", inst_pc, 32'h40);
        chk("t6_data", inst_data, 32'h0100_006F);
        chk("t6_pred", inst_pred_taken, PRED_EN);

        // Random traffic against the model, including unaligned and wrapping redirect targets.
        lat_lo = 0; lat_hi = 3; pops = 0;
        for (int i = 0; i < 3000; i++) begin
            k_rdy    = ($urandom % 10) != 0;
            k_mrdy   = ($urandom % 4) != 0;
            k_drdy   = ($urandom % 3) != 0;
            k_redir  = ($urandom % 40) == 0;
            k_rpc    = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : ($urandom % 1024);
            frc_resp = $urandom % 2;
            tick();
        end
        chk("rand_progress", pops > 200, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
